warp_scoreboard_tracker: RTL and testbench

- Issue-side responder to the warp scheduler: consumes the per-cycle multi-hot issue mask and produces the per-warp `scoreboard` (1 = blocked) vector that the scheduler masks against `ready_mask`.
- Tracks two kinds of in-flight work per warp:
  - fixed-latency ALU ops, via a countdown timer;
  - variable-latency memory ops, via a pending counter retired by a writeback port.
- Sits between the scheduler's select output and the execute/LSU writeback path.

---
 rtl/warp_scoreboard_tracker_if.sv | 41 ++++
 rtl/warp_scoreboard_tracker.sv | 157 +++++++++++++++
 tb/tb_warp_scoreboard_tracker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_scoreboard_tracker_if.sv
// Issue/writeback bus between the warp scheduler and the scoreboard tracker.
// The scheduler side drives the issue mask, op types and writebacks. The tracker
// side returns the per-warp blocked vector, the idle flag and the sticky error flags.
interface warp_scoreboard_tracker_if #(
   parameter int WARP_CNT = 64,
   parameter int IDX_W    = $clog2(WARP_CNT)
);
   logic [WARP_CNT-1:0] issue_mask;
   logic [WARP_CNT-1:0] issue_mem;
   logic                wb_valid;
   logic [IDX_W-1:0]    wb_idx;
   logic                err_clr;
   logic [WARP_CNT-1:0] scoreboard;
   logic                idle;
   logic                err_overflow;
   logic                err_underflow;

   modport master (
      output issue_mask,
      output issue_mem,
      output wb_valid,
      output wb_idx,
      output err_clr,
      input  scoreboard,
      input  idle,
      input  err_overflow,
      input  err_underflow
   );

   modport slave (
      input  issue_mask,
      input  issue_mem,
      input  wb_valid,
      input  wb_idx,
      input  err_clr,
      output scoreboard,
      output idle,
      output err_overflow,
      output err_underflow
   );
endinterface

// File: rtl/warp_scoreboard_tracker.sv
// Per-warp scoreboard for the warp scheduler.
// Each warp carries two pieces of state:
// - a down-counting ALU timer, reloaded on every ALU issue;
// - a count of outstanding memory ops, retired by the writeback port.
// A warp is blocked while its timer is running or its memory count is saturated.
// All outputs are decoded from registered state only.
// Optional build macro WSB_FLUSH_EN adds a `flush` input that discards all
// in-flight state in one cycle.
//
// per-warp state | meaning
// tmr == 0       | no ALU op in flight
// tmr != 0       | ALU result pending; the warp is blocked
// cnt < MEM_MAX  | memory ops outstanding, more may issue
// cnt == MEM_MAX | memory queue full; the warp is blocked
module warp_scoreboard_tracker #(
   parameter int WARP_CNT = 64,
   parameter int IDX_W    = $clog2(WARP_CNT),
   parameter int ALU_LAT  = 4,
   parameter int MEM_MAX  = 3,
   parameter int TMR_W    = $clog2(ALU_LAT + 1),
   parameter int CNT_W    = $clog2(MEM_MAX + 1)
) (
   input  logic clk,
   input  logic rst_n,
`ifdef WSB_FLUSH_EN
   input  logic flush,
`endif
   warp_scoreboard_tracker_if.slave bus
);

   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ALU_LAT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_MAX);
   localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W+1)'(WARP_CNT);

   logic [TMR_W-1:0] tmr_q [WARP_CNT];
   logic [TMR_W-1:0] tmr_d [WARP_CNT];
   logic [CNT_W-1:0] cnt_q [WARP_CNT];
   logic [CNT_W-1:0] cnt_d [WARP_CNT];

   logic err_overflow_q;
   logic err_overflow_d;
   logic err_underflow_q;
   logic err_underflow_d;

   logic flush_w;
   logic wb_oob;
   logic ovf_evt;
   logic unf_evt;

`ifdef WSB_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // A writeback index beyond the last warp retires nothing but counts as an underflow.
   assign wb_oob = bus.wb_valid && ({1'b0, bus.wb_idx} >= IDX_LIM);

   // Next-state for every warp's timer and memory counter, plus this cycle's error events.
   always_comb begin
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      for (int w = 0; w < WARP_CNT; w++) begin
         logic inc;
         logic dec;
         logic alu;
         tmr_d[w] = tmr_q[w];
         cnt_d[w] = cnt_q[w];
         alu = bus.issue_mask[w] & ~bus.issue_mem[w];
         inc = bus.issue_mask[w] &  bus.issue_mem[w];
         dec = bus.wb_valid && (bus.wb_idx == IDX_W'(w));

         if (alu) begin
            tmr_d[w] = TMR_LOAD;
         end else if (tmr_q[w] != '0) begin
            tmr_d[w] = tmr_q[w] - 1'b1;
         end

         // An issue and a writeback in the same cycle cancel out, even at the limits.
         if (inc && !dec) begin
            if (cnt_q[w] != CNT_FULL) begin
               cnt_d[w] = cnt_q[w] + 1'b1;
            end else begin
               ovf_evt = 1'b1;
            end
         end else if (dec && !inc) begin
            if (cnt_q[w] != '0) begin
               cnt_d[w] = cnt_q[w] - 1'b1;
            end else begin
               unf_evt = 1'b1;
            end
         end

         if (flush_w) begin
            tmr_d[w] = '0;
            cnt_d[w] = '0;
         end
      end

      if (wb_oob) begin
         unf_evt = 1'b1;
      end

      // Work discarded by a flush cannot raise errors.
      if (flush_w) begin
         ovf_evt = 1'b0;
         unf_evt = 1'b0;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_comb begin
      err_overflow_d  = (err_overflow_q  & ~bus.err_clr) | ovf_evt;
      err_underflow_d = (err_underflow_q & ~bus.err_clr) | unf_evt;
   end

   // Per-warp timer and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < WARP_CNT; w++) begin
            tmr_q[w] <= '0;
            cnt_q[w] <= '0;
         end
      end else begin
         for (int w = 0; w < WARP_CNT; w++) begin
            tmr_q[w] <= tmr_d[w];
            cnt_q[w] <= cnt_d[w];
         end
      end
   end

   // Error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   // Blocked vector and idle flag, decoded from the registered per-warp state.
   always_comb begin
      bus.idle = 1'b1;
      for (int w = 0; w < WARP_CNT; w++) begin
         bus.scoreboard[w] = (tmr_q[w] != '0) || (cnt_q[w] == CNT_FULL);
         if ((tmr_q[w] != '0) || (cnt_q[w] != '0)) begin
            bus.idle = 1'b0;
         end
      end
   end

   assign bus.err_overflow  = err_overflow_q;
   assign bus.err_underflow = err_underflow_q;

endmodule

// File: tb/tb_warp_scoreboard_tracker.sv
// Directed bench for warp_scoreboard_tracker (WARP_CNT=64, ALU_LAT=4, MEM_MAX=3).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_warp_scoreboard_tracker;
   localparam int WARP_CNT = 64;
   localparam int IDX_W    = 6;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   warp_scoreboard_tracker_if #(.WARP_CNT(WARP_CNT), .IDX_W(IDX_W)) bus ();

`ifdef WSB_FLUSH_EN
   logic flush;
`endif

   warp_scoreboard_tracker #(
      .WARP_CNT(WARP_CNT),
      .IDX_W   (IDX_W),
      .ALU_LAT (4),
      .MEM_MAX (3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
`ifdef WSB_FLUSH_EN
      .flush(flush),
`endif
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.issue_mask = '0;
      bus.issue_mem  = '0;
      bus.wb_valid   = 1'b0;
      bus.wb_idx     = '0;
      bus.err_clr    = 1'b0;
   endtask

   task automatic mem_issue(input int w);
      bus.issue_mask = '0;
      bus.issue_mem  = '0;
      bus.issue_mask[w] = 1'b1;
      bus.issue_mem[w]  = 1'b1;
   endtask

   task automatic alu_issue(input int w);
      bus.issue_mask = '0;
      bus.issue_mem  = '0;
      bus.issue_mask[w] = 1'b1;
   endtask

   task automatic wb(input int w);
      bus.wb_valid = 1'b1;
      bus.wb_idx   = IDX_W'(w);
   endtask

   logic [63:0] b5, b2, b7, b0;

   initial begin
      errors = 0;
      checks = 0;
      b5 = 64'h20;
      b2 = 64'h4;
      b7 = 64'h80;
      b0 = 64'h1;
`ifdef WSB_FLUSH_EN
      flush = 1'b0;
`endif
      idle_in();
      rst_n = 1'b0;

      // Reset held with random issue traffic
      for (int i = 0; i < 3; i++) begin
         bus.issue_mask = {$urandom, $urandom};
         bus.issue_mem  = {$urandom, $urandom};
         step();
      end
      chk("rst_sb", bus.scoreboard, 64'h0);
      chk("rst_idle", 64'(bus.idle), 64'h1);
      chk("rst_ovf", 64'(bus.err_overflow), 64'h0);
      chk("rst_unf", 64'(bus.err_underflow), 64'h0);
      idle_in();
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_sb", bus.scoreboard, 64'h0);
      chk("post_rst_idle", 64'(bus.idle), 64'h1);

      // ALU latency on warp 5: blocked for exactly 4 cycles
      alu_issue(5);
      step();
      idle_in();
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("alu_c%0d", k), bus.scoreboard, b5);
         step();
      end
      chk("alu_c5", bus.scoreboard, 64'h0);
      chk("alu_idle", 64'(bus.idle), 64'h1);

      // Reissue two edges later stretches blocking to N+6
      alu_issue(5);
      step();
      idle_in();
      step();
      alu_issue(5);
      step();
      idle_in();
      for (int k = 3; k <= 6; k++) begin
         chk($sformatf("realu_c%0d", k), bus.scoreboard, b5);
         step();
      end
      chk("realu_c7", bus.scoreboard, 64'h0);

      // Memory saturation on warp 2
      mem_issue(2);
      step();
      chk("mem1_sb", bus.scoreboard, 64'h0);
      chk("mem1_idle", 64'(bus.idle), 64'h0);
      step();
      chk("mem2_sb", bus.scoreboard, 64'h0);
      step();
      chk("mem3_sb", bus.scoreboard, b2);
      chk("mem3_ovf", 64'(bus.err_overflow), 64'h0);
      step();
      idle_in();
      chk("mem4_ovf", 64'(bus.err_overflow), 64'h1);
      chk("mem4_sb", bus.scoreboard, b2);
      wb(2);
      step();
      idle_in();
      chk("wb1_sb", bus.scoreboard, 64'h0);
      chk("wb1_idle", 64'(bus.idle), 64'h0);
      wb(2);
      step();
      wb(2);
      step();
      idle_in();
      chk("drain_idle", 64'(bus.idle), 64'h1);
      chk("drain_unf", 64'(bus.err_underflow), 64'h0);
      chk("ovf_sticky", 64'(bus.err_overflow), 64'h1);
      bus.err_clr = 1'b1;
      step();
      idle_in();
      chk("ovf_clr", 64'(bus.err_overflow), 64'h0);

      // Warp 7 full: issue and writeback together leave the count at 3
      mem_issue(7);
      step();
      step();
      step();
      wb(7);
      step();
      idle_in();
      chk("sim7_sb", bus.scoreboard, b7);
      chk("sim7_ovf", 64'(bus.err_overflow), 64'h0);
      for (int i = 0; i < 3; i++) begin
         wb(7);
         step();
      end
      idle_in();
      chk("sim7_idle", 64'(bus.idle), 64'h1);
      chk("sim7_unf", 64'(bus.err_underflow), 64'h0);

      // Warp 8 empty: issue and writeback together leave the count at 0
      mem_issue(8);
      wb(8);
      step();
      idle_in();
      chk("sim8_idle", 64'(bus.idle), 64'h1);
      chk("sim8_unf", 64'(bus.err_underflow), 64'h0);

      // Multi-hot at both boundary warps: warp 0 ALU, warp 63 memory
      bus.issue_mask = '0;
      bus.issue_mem  = '0;
      bus.issue_mask[0]  = 1'b1;
      bus.issue_mask[63] = 1'b1;
      bus.issue_mem[63]  = 1'b1;
      step();
      idle_in();
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("mh_c%0d", k), bus.scoreboard, b0);
         step();
      end
      chk("mh_c5_sb", bus.scoreboard, 64'h0);
      chk("mh_c5_idle", 64'(bus.idle), 64'h0);
      wb(63);
      step();
      idle_in();
      chk("mh_wb63_idle", 64'(bus.idle), 64'h1);
      chk("mh_wb63_unf", 64'(bus.err_underflow), 64'h0);

      // Underflow on warp 9, then clear, then set-wins
      wb(9);
      step();
      idle_in();
      chk("unf9", 64'(bus.err_underflow), 64'h1);
      bus.err_clr = 1'b1;
      step();
      idle_in();
      chk("unf_clr", 64'(bus.err_underflow), 64'h0);
      bus.err_clr = 1'b1;
      wb(9);
      step();
      idle_in();
      chk("unf_setwins", 64'(bus.err_underflow), 64'h1);
      bus.err_clr = 1'b1;
      step();
      idle_in();
      chk("unf_clr2", 64'(bus.err_underflow), 64'h0);

      // Asynchronous reset mid-operation drops in-flight state at once
      alu_issue(5);
      step();
      mem_issue(2);
      step();
      step();
      step();
      idle_in();
      chk("pre_arst_sb", bus.scoreboard, b2 | b5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sb", bus.scoreboard, 64'h0);
      chk("arst_idle", 64'(bus.idle), 64'h1);
      step();
      rst_n = 1'b1;
      step();

`ifdef WSB_FLUSH_EN
      // Flush with warps 1..3 busy and a simultaneous issue to warp 4
      alu_issue(1);
      step();
      mem_issue(2);
      step();
      step();
      step();
      alu_issue(3);
      step();
      alu_issue(4);
      wb(9);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle_in();
      chk("flush_sb", bus.scoreboard, 64'h0);
      chk("flush_idle", 64'(bus.idle), 64'h1);
      chk("flush_unf", 64'(bus.err_underflow), 64'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
